// File: rtl/retire_trace_pkg.sv
// Shared types and constants for the retire trace buffer.
// RETIRE_TRACE_TIMESTAMP_EN adds a 32-bit cycle stamp to every entry.
package retire_trace_pkg;

  localparam logic       KIND_GRF = 1'b0;
  localparam logic       KIND_DM  = 1'b1;
  localparam logic [3:0] BE_FULL  = 4'b1111;
  localparam logic [15:0] DROP_MAX = 16'hFFFF;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    logic [31:0] stamp;
`endif
  } entry_t;

endpackage

// File: rtl/trace_fifo_2w1r.sv
// Event queue with two ordered write ports (port 1 lands after port 0) and
// one show-ahead read port; the caller guarantees writes never exceed free space.
module trace_fifo_2w1r
  import retire_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr0_en,
  input  entry_t                   wr0_data,
  input  logic                     wr1_en,
  input  entry_t                   wr1_data,
  input  logic                     rd_en,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] wr_ptr1;
  logic [PTR_W-1:0] rd_ptr;
  logic [1:0]       n_wr;

  assign wr_ptr1 = wr_ptr + PTR_W'(1);
  assign n_wr    = {1'b0, wr0_en} + {1'b0, wr1_en};
  assign head    = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero while empty after reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr0_en) mem[wr_ptr]  <= wr0_data;
      if (wr1_en) mem[wr_ptr1] <= wr1_data;
      wr_ptr <= wr_ptr + PTR_W'(n_wr);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      count  <= count + CNT_W'(n_wr) - CNT_W'(rd_en);
    end
  end

endmodule

// File: rtl/retire_trace_buffer.sv
// Captures GRF retires (W) and DM stores (M) in program order and drains them
// over valid/ready. Optional macro RETIRE_TRACE_TIMESTAMP_EN adds out_time.
module retire_trace_buffer
  import retire_trace_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        w_valid,
  input  logic [31:0] w_pc,
  input  logic        w_we,
  input  logic [4:0]  w_addr,
  input  logic [31:0] w_data,
  input  logic        m_valid,
  input  logic [31:0] m_pc,
  input  logic [3:0]  m_be,
  input  logic [31:0] m_addr,
  input  logic [31:0] m_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_kind,
  output logic [31:0] out_pc,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic [3:0]  out_be,
`ifdef RETIRE_TRACE_TIMESTAMP_EN
  output logic [31:0] out_time,
`endif
  output logic        overflow,
  output logic [15:0] drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SP_W  = CNT_W + 1;

  logic             grf_ev;
  logic             dm_ev;
  logic             pop;
  logic [1:0]       push_n;
  logic [1:0]       accepted;
  logic [1:0]       drop_n;
  logic [SP_W-1:0]  space;
  logic [CNT_W-1:0] count;
  logic [16:0]      drop_sum;
  entry_t           grf_e;
  entry_t           dm_e;
  entry_t           wr0_data;
  entry_t           head;

`ifdef RETIRE_TRACE_TIMESTAMP_EN
  logic [31:0] cycle;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cycle <= '0;
    else        cycle <= cycle + 32'd1;
  end

  assign out_time = head.stamp;
`endif

  assign grf_ev = w_valid & w_we & (w_addr != 5'd0);
  assign dm_ev  = m_valid & (m_be != 4'd0);

  // Pack both candidate events into queue entries.
  always_comb begin
    grf_e      = '0;
    grf_e.kind = KIND_GRF;
    grf_e.pc   = w_pc;
    grf_e.addr = {27'd0, w_addr};
    grf_e.data = w_data;
    grf_e.be   = BE_FULL;
    dm_e       = '0;
    dm_e.kind  = KIND_DM;
    dm_e.pc    = m_pc;
    dm_e.addr  = m_addr;
    dm_e.data  = m_data;
    dm_e.be    = m_be;
`ifdef RETIRE_TRACE_TIMESTAMP_EN
    grf_e.stamp = cycle;
    dm_e.stamp  = cycle;
`endif
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push_n    = {1'b0, grf_ev} + {1'b0, dm_ev};

  // A same-cycle pop frees a slot; when short of space the newest event is dropped.
  assign space    = SP_W'(DEPTH) - SP_W'(count) + SP_W'(pop);
  assign accepted = (space >= SP_W'(push_n)) ? push_n : space[1:0];
  assign drop_n   = push_n - accepted;
  assign wr0_data = grf_ev ? grf_e : dm_e;
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_n);

  trace_fifo_2w1r #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .wr0_en   (accepted != 2'd0),
    .wr0_data (wr0_data),
    .wr1_en   (accepted == 2'd2),
    .wr1_data (dm_e),
    .rd_en    (pop),
    .head     (head),
    .count    (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop_n != 2'd0) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[16] ? DROP_MAX : drop_sum[15:0];
    end
  end

  assign out_kind = head.kind;
  assign out_pc   = head.pc;
  assign out_addr = head.addr;
  assign out_data = head.data;
  assign out_be   = head.be;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Scoreboard bench for retire_trace_buffer: directed stimulus pushes expected
// beats into a queue; a negedge monitor pops and compares every accepted beat.
module tb_retire_trace_buffer;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_valid, w_we, m_valid, out_ready;
  logic [31:0] w_pc, w_data, m_pc, m_addr, m_data;
  logic [4:0]  w_addr;
  logic [3:0]  m_be;
  logic        out_valid, out_kind, overflow;
  logic [31:0] out_pc, out_addr, out_data;
  logic [3:0]  out_be;
  logic [15:0] drop_cnt;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(16)) dut (
    .clk(clk), .reset(reset),
    .w_valid(w_valid), .w_pc(w_pc), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
    .m_valid(m_valid), .m_pc(m_pc), .m_be(m_be), .m_addr(m_addr), .m_data(m_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_kind(out_kind),
    .out_pc(out_pc), .out_addr(out_addr), .out_data(out_data), .out_be(out_be),
    .overflow(overflow), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Monitor: every beat the sink accepts must match the oldest expected beat.
  always @(negedge clk) begin
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      beat_t got;
      beat_t req;
      got = '{kind: out_kind, pc: out_pc, addr: out_addr, data: out_data, be: out_be};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL beat_unexpected: got pc=%h kind=%0d, required no beat", out_pc, out_kind);
      end else begin
        req = exp_q.pop_front();
        if (got !== req) begin
          n_err++;
          $display("FAIL beat: got k=%0d pc=%h a=%h d=%h be=%b, required k=%0d pc=%h a=%h d=%h be=%b",
                   got.kind, got.pc, got.addr, got.data, got.be,
                   req.kind, req.pc, req.addr, req.data, req.be);
        end
      end
    end
  end

  task automatic idle();
    w_valid = 1'b0; w_we = 1'b0; w_pc = '0; w_addr = '0; w_data = '0;
    m_valid = 1'b0; m_pc = '0; m_be = '0; m_addr = '0; m_data = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_w(input logic [31:0] pc, input logic [4:0] a, input logic [31:0] d, input bit expect_it);
    w_valid = 1'b1; w_we = 1'b1; w_pc = pc; w_addr = a; w_data = d;
    if (expect_it) exp_q.push_back('{kind: 1'b0, pc: pc, addr: {27'd0, a}, data: d, be: 4'b1111});
  endtask

  task automatic set_m(input logic [31:0] pc, input logic [31:0] a, input logic [3:0] be,
                       input logic [31:0] d, input bit expect_it);
    m_valid = 1'b1; m_pc = pc; m_addr = a; m_be = be; m_data = d;
    if (expect_it) exp_q.push_back('{kind: 1'b1, pc: pc, addr: a, data: d, be: be});
  endtask

  task automatic drain(input string name);
    out_ready = 1'b1;
    for (int k = 0; k < 100 && exp_q.size() != 0; k++) step();
    step();
    chk({name, "_left"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_empty"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    out_ready = 1'b0;
    idle();
    #3;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_be", {28'd0, out_be}, 32'd0);
    step();
    #2 reset = 1'b1;
    step();

    // Isolated GRF write; no pass-through while empty.
    out_ready = 1'b1;
    set_w(32'h3000, 5'd8, 32'h0000_1234, 1'b1);
    #1 chk("no_passthru", {31'd0, out_valid}, 32'd0);
    step();
    idle();
    chk("latency_valid", {31'd0, out_valid}, 32'd1);
    drain("single");

    // $0 and bubble filtering.
    w_valid = 1'b1; w_we = 1'b1; w_addr = 5'd0; w_pc = 32'h3100; w_data = 32'h55;
    step();
    idle();
    chk("r0_filtered", {31'd0, out_valid}, 32'd0);
    w_valid = 1'b0; w_we = 1'b1; w_addr = 5'd5; w_pc = 32'h3104; w_data = 32'h66;
    m_valid = 1'b0; m_be = 4'b1111;
    step();
    idle();
    chk("bubble_filtered", {31'd0, out_valid}, 32'd0);

    // Same-cycle W and M: W first.
    set_w(32'h3004, 5'd9, 32'd5, 1'b1);
    set_m(32'h3008, 32'h10, 4'b1111, 32'd7, 1'b1);
    step();
    idle();
    drain("dual");

    // Fill to 15 singles, then a double: M dropped.
    out_ready = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i % 2 == 0) set_w(32'h4000 + 32'(4 * i), 5'(i + 1), 32'hA000 + 32'(i), 1'b1);
      else            set_m(32'h4000 + 32'(4 * i), 32'h200 + 32'(4 * i), 4'b1100, 32'hB000 + 32'(i), 1'b1);
      step();
      idle();
    end
    set_w(32'h4100, 5'd3, 32'h0000_C0DE, 1'b1);
    set_m(32'h4104, 32'h300, 4'b1111, 32'h0000_DEAD, 1'b0);
    step();
    idle();
    chk("fill_overflow", {31'd0, overflow}, 32'd1);
    chk("fill_drop", {16'd0, drop_cnt}, 32'd1);
    chk("fill_head_stable", out_pc, 32'h4000);

    // Full with same-cycle pop accepts; next push with no pop drops.
    out_ready = 1'b1;
    set_w(32'h6000, 5'd4, 32'hBB, 1'b1);
    step();
    idle();
    chk("full_pop_nodrop", {16'd0, drop_cnt}, 32'd1);
    out_ready = 1'b0;
    set_w(32'h6004, 5'd6, 32'hEE, 1'b0);
    step();
    idle();
    chk("full_drop", {16'd0, drop_cnt}, 32'd2);
    chk("full_head", out_pc, 32'h4004);
    drain("fill");
    chk("overflow_sticky", {31'd0, overflow}, 32'd1);

    // Async reset mid-drain discards queued entries.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_w(32'h7000 + 32'(4 * i), 5'(i + 1), 32'(i), 1'b1);
      step();
      idle();
    end
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_overflow", {31'd0, overflow}, 32'd0);
    chk("midrst_drop", {16'd0, drop_cnt}, 32'd0);
    exp_q.delete();
    out_ready = 1'b1;
    set_w(32'h7100, 5'd31, 32'hCC, 1'b1);
    #1 reset = 1'b1;
    step();
    idle();
    chk("post_rst_valid", {31'd0, out_valid}, 32'd1);
    chk("post_rst_pc", out_pc, 32'h7100);
    drain("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/retire_trace_buffer.md
Name: retire_trace_buffer

Overview:
- Synthesizable trace buffer that sits downstream of the 5-stage mips core.
- Captures architectural side effects as the core produces them:
  - GRF writes from W, at retire.
  - DM stores from M.
- Queues the events in program order and drains them through a valid/ready port to a trace sink (bench checker or UART dumper).
- Replaces ad-hoc simulation prints with a cycle-exact, checkable event stream.

Parameters:
- DEPTH, 16, entries in the queue; power of two, minimum 4.
- PTR_W, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low; reset==0 clears all state immediately.
- w_valid  in  1  W stage holds a real (non-bubble) instruction this cycle.
- w_pc  in  32  PC of the W instruction.
- w_we  in  1  W instruction writes GRF.
- w_addr  in  5  GRF destination.
- w_data  in  32  GRF write data.
- m_valid  in  1  M stage holds a real instruction this cycle.
- m_pc  in  32  PC of the M instruction.
- m_be  in  4  DM byte enables; nonzero means store.
- m_addr  in  32  DM byte address (word-aligned for the store).
- m_data  in  32  DM write data, already lane-aligned.
- out_valid  out  1  head entry available.
- out_ready  in  1  sink accepts head.
- out_kind  out  1  0=GRF event, 1=DM event.
- out_pc  out  32  event PC.
- out_addr  out  32  GRF index zero-extended, or DM address.
- out_data  out  32  written data.
- out_be  out  4  DM byte enables; 4'b1111 for GRF events.
- overflow  out  1  sticky: at least one event dropped.
- drop_cnt  out  16  number of dropped events, saturating at 16'hFFFF.

Behaviour:
- Reset (reset==0, async): wr_ptr=rd_ptr=0, count=0; out_valid=0; out_kind/out_pc/out_addr/out_data/out_be=0; overflow=0; drop_cnt=0.
- Event qualification:
  - GRF event = w_valid & w_we & (w_addr!=0).
  - DM event = m_valid & (m_be!=0).
- Ordering:
  - When both events occur in one cycle, the W event is older and is written first (slot wr_ptr).
  - The M event goes to slot wr_ptr+1.
- Push and pop per cycle:
  - push_n ∈ {0,1,2}.
  - pop = out_valid & out_ready.
  - count_next = count + accepted pushes − pop.
- Space check:
  - Free space is computed as DEPTH − count + pop, so a same-cycle pop frees a slot.
- Overflow:
  - If accepted < push_n, the newest event(s) are dropped: the M event first, then the W event.
  - Set overflow; add the number dropped to drop_cnt (saturating).
  - Accepted events keep order; there is never a partial entry.
- Pointers: wrap modulo DEPTH (PTR_W bits). Full is count==DEPTH; empty is count==0.
- Output timing:
  - Registered show-ahead. Head fields come straight from storage[rd_ptr] and are stable while out_valid & !out_ready.
  - out_valid = (count!=0).
  - Latency: an event pushed in cycle N is visible at the head in N+1 when the queue was empty.
- Empty queue with simultaneous push and out_ready: no pass-through; out_valid rises next cycle.
- No stall input: the core is never back-pressured. Loss is reported only via overflow/drop_cnt.
- Reset mid-drain discards all queued entries. The first event after reset release is captured on the first rising edge with reset==1.

Optional Feature:
- RETIRE_TRACE_TIMESTAMP_EN defined:
  - Adds output out_time[31:0].
  - A free-running 32-bit cycle counter is cleared by reset and incremented every clk edge, wrapping at 2^32.
  - Each entry stores the counter value at its push cycle; W and M events pushed in the same cycle carry equal stamps.
- Not defined: no out_time port, no counter, and entry width reduced accordingly.

Decomposition:
- Package retire_trace_pkg:
  - Entry struct {kind, pc, addr, data, be[, time]}.
  - KIND_GRF=1'b0, KIND_DM=1'b1.
  - BE_FULL=4'b1111.
  - DROP_MAX=16'hFFFF.
- One sub-module, trace_fifo_2w1r:
  - Storage array plus pointers/count with two ordered write ports and one read port.
  - The top level does qualification, packing, and overflow accounting.

Test Plan:
- Isolated GRF write: w_valid=1, w_we=1, w_addr=8, w_data=32'h0000_1234, w_pc=32'h3000 for one cycle, out_ready=1 → next cycle exactly one beat: kind=0, addr=8, data=1234, be=1111, pc=3000.
- $0 and bubble filtering: w_addr=0 with w_we=1, then w_valid=0 with w_we=1 → out_valid stays 0; count stays 0.
- Same-cycle W and M: W (pc 3004, $9←5), M sw (pc 3008, addr 0x10, be 1111, data 7) → two beats in order: 3004 GRF, then 3008 DM.
- Fill and overflow: out_ready=0, push 15 single events, then one double event → the W event is accepted (count=16); M is dropped; overflow=1, drop_cnt=1; draining returns 16 entries in push order.
- Full with same-cycle pop: count=16, out_ready=1, single push → accepted; count stays 16; no drop.
- Async reset mid-drain: count=5, pull reset low between edges → out_valid=0 immediately; overflow=0, drop_cnt=0; after release, a new event appears as the sole entry.
